// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - fetch stage control, instruction memory and IF/ID signal bundle
interface fetch_stage_if;
    logic        i_stall;
    logic        i_flush;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_gnt;
    logic        i_imem_rvalid;
    logic [31:0] i_imem_rdata;
    logic        o_id_valid;
    logic [31:0] o_id_instr;
    logic [31:0] o_id_pc;
    logic [31:0] o_id_pc4;

    modport master (
        input  i_stall, i_flush, i_redirect, i_redirect_pc,
        input  i_imem_gnt, i_imem_rvalid, i_imem_rdata,
        output o_imem_req, o_imem_addr,
        output o_id_valid, o_id_instr, o_id_pc, o_id_pc4
    );

    modport slave (
        output i_stall, i_flush, i_redirect, i_redirect_pc,
        output i_imem_gnt, i_imem_rvalid, i_imem_rdata,
        input  o_imem_req, o_imem_addr,
        input  o_id_valid, o_id_instr, o_id_pc, o_id_pc4
    );
endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch with one outstanding request, skid buffer and IF/ID register
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    fetch_stage_if.master bus
);
    typedef enum logic [1:0] {F_REQ, F_WAIT, F_DROP} fetch_state_e;

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  req_pc_q, req_pc_d;
    logic         skid_valid_q, skid_valid_d;
    logic [31:0]  skid_instr_q, skid_instr_d;
    logic [31:0]  skid_pc_q, skid_pc_d;
    logic         id_valid_q, id_valid_d;
    logic [31:0]  id_instr_q, id_instr_d;
    logic [31:0]  id_pc_q, id_pc_d;
    logic [31:0]  id_pc4_q, id_pc4_d;

    logic imem_req, id_loadable, rsp_accept, skid_drain, rsp_to_slot, rsp_to_skid;

    always_comb begin
        imem_req    = (state_q == F_REQ) && !skid_valid_q && !bus.i_redirect;
        id_loadable = !id_valid_q || !bus.i_stall;
        rsp_accept  = (state_q == F_WAIT) && bus.i_imem_rvalid && !bus.i_redirect;
        skid_drain  = skid_valid_q && id_loadable && !bus.i_redirect;
        // A buffered instruction is older than any new response, so it wins the slot.
        rsp_to_slot = rsp_accept && id_loadable && !skid_valid_q;
        rsp_to_skid = rsp_accept && !rsp_to_slot;
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        case (state_q)
            F_REQ: begin
                if (imem_req && bus.i_imem_gnt) begin
                    req_pc_d = pc_q;
                    pc_d     = pc_q + 32'd4;
                    state_d  = F_WAIT;
                end
            end
            F_WAIT: begin
                if (bus.i_imem_rvalid)   state_d = F_REQ;
                else if (bus.i_redirect) state_d = F_DROP;
            end
            F_DROP: begin
                if (bus.i_imem_rvalid) state_d = F_REQ;
            end
            default: state_d = F_REQ;
        endcase
        if (bus.i_redirect) pc_d = {bus.i_redirect_pc[31:2], 2'b00};
    end

    always_comb begin
        skid_valid_d = skid_valid_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        if (bus.i_redirect) begin
            skid_valid_d = 1'b0;
        end else if (rsp_to_skid) begin
            skid_valid_d = 1'b1;
            skid_instr_d = bus.i_imem_rdata;
            skid_pc_d    = req_pc_q;
        end else if (skid_drain && !bus.i_flush) begin
            skid_valid_d = 1'b0;
        end
    end

    always_comb begin
        id_valid_d = id_valid_q;
        id_instr_d = id_instr_q;
        id_pc_d    = id_pc_q;
        id_pc4_d   = id_pc4_q;
        if (bus.i_flush) begin
            id_valid_d = 1'b0;
            id_instr_d = NOP_INSTR;
        end else if (skid_drain) begin
            id_valid_d = 1'b1;
            id_instr_d = skid_instr_q;
            id_pc_d    = skid_pc_q;
            id_pc4_d   = skid_pc_q + 32'd4;
        end else if (rsp_to_slot) begin
            id_valid_d = 1'b1;
            id_instr_d = bus.i_imem_rdata;
            id_pc_d    = req_pc_q;
            id_pc4_d   = req_pc_q + 32'd4;
        end else if (!bus.i_stall) begin
            // Decode took the slot (or it was already empty); pc/pc4 keep their last values.
            id_valid_d = 1'b0;
            id_instr_d = NOP_INSTR;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= F_REQ;
            pc_q         <= RESET_PC;
            req_pc_q     <= RESET_PC;
            skid_valid_q <= 1'b0;
            skid_instr_q <= NOP_INSTR;
            skid_pc_q    <= 32'd0;
            id_valid_q   <= 1'b0;
            id_instr_q   <= NOP_INSTR;
            id_pc_q      <= 32'd0;
            id_pc4_q     <= 32'd0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_pc_q     <= req_pc_d;
            skid_valid_q <= skid_valid_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            id_valid_q   <= id_valid_d;
            id_instr_q   <= id_instr_d;
            id_pc_q      <= id_pc_d;
            id_pc4_q     <= id_pc4_d;
        end
    end

    assign bus.o_imem_req  = imem_req;
    assign bus.o_imem_addr = pc_q;
    assign bus.o_id_valid  = id_valid_q;
    assign bus.o_id_instr  = id_instr_q;
    assign bus.o_id_pc     = id_pc_q;
    assign bus.o_id_pc4    = id_pc4_q;
endmodule
